// File: rtl/mul4_seq_ctrl_pkg.sv
// mul4_pkg: shared types and constants for the sequential shift-and-add
// multiplier controller.
//   state_t  : controller FSM states (IDLE, RUN, DONE)
//   W_DEF    : default operand width in bits
//   prod_w() : product width for a given operand width (2W)
package mul4_pkg;

    localparam int W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mul4_seq_ctrl_if.sv
// mul4_seq_ctrl_if: start/busy/done handshake plus operand and product buses.
//   start : request, sampled by the controller only while idle
//   a, b  : W-bit unsigned multiplicand / multiplier
//   busy  : controller is in RUN or DONE
//   done  : one-cycle pulse, p valid from this cycle
//   p     : 2W-bit product, held until the next completion
// master modport is the requester, slave modport is the controller.
interface mul4_seq_ctrl_if
    import mul4_pkg::*;
#(
    parameter int W = W_DEF
) ();

    logic                 start;
    logic [W-1:0]         a;
    logic [W-1:0]         b;
    logic                 busy;
    logic                 done;
    logic [prod_w(W)-1:0] p;

    modport master (output start, a, b, input busy, done, p);
    modport slave  (input start, a, b, output busy, done, p);

endinterface

// File: rtl/mul4_seq_ctrl_add4_ripple.sv
// add4_ripple: W-bit ripple-carry adder made of a chain of full-adder cells.
// Purely combinational.
//   x, y : addends
//   cin  : carry into bit 0
//   sum  : W-bit sum
//   cout : carry out of the MSB cell
module add4_ripple #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]  = x[i] ^ y[i] ^ c[i];
        assign c[i+1]  = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[W];

endmodule

// File: rtl/mul4_seq_ctrl.sv
// mul4_seq_ctrl: sequential shift-and-add multiplier controller. One W-bit
// ripple adder is reused over W RUN cycles to build a 2W-bit unsigned product.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mul4_seq_ctrl_if.slave (start, a, b in; busy, done, p out)
// Build option: define MUL4_ZERO_SKIP_EN to complete in one cycle with p=0
// when either operand is zero at accept.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; operands captured on accept
//   RUN   | one conditional add + right shift per cycle, W cycles total
//   DONE  | done pulse, p holds the new product; back to IDLE next edge
module mul4_seq_ctrl
    import mul4_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul4_seq_ctrl_if.slave       bus
);

    localparam int             PW       = prod_w(W);
    localparam int             CW       = $clog2(W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);

    state_t          state_q, state_d;
    logic [W-1:0]    mcand_q, hi_q, lo_q;
    logic [W-1:0]    hi_d, lo_d;
    logic [W-1:0]    sum;
    logic            carry;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   p_q;
    logic            zero_op;
    logic            last_iter;

    add4_ripple #(.W(W)) u_add (
        .x    (hi_q),
        .y    (mcand_q),
        .cin  (1'b0),
        .sum  (sum),
        .cout (carry)
    );

`ifdef MUL4_ZERO_SKIP_EN
    assign zero_op = (bus.a == '0) || (bus.b == '0);
`else
    assign zero_op = 1'b0;
`endif

    assign last_iter = (cnt_q == CNT_LAST);

    // Carry-out lands in the MSB of hi after the shift, so nothing is lost.
    always_comb begin
        hi_d = {1'b0, hi_q[W-1:1]};
        lo_d = {hi_q[0], lo_q[W-1:1]};
        if (lo_q[0]) begin
            hi_d = {carry, sum[W-1:1]};
            lo_d = {sum[0], lo_q[W-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = zero_op ? DONE : RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mcand_q <= bus.a;
                        hi_q    <= '0;
                        lo_q    <= bus.b;
                        cnt_q   <= '0;
                        if (zero_op) p_q <= '0;
                    end
                end
                RUN: begin
                    hi_q <= hi_d;
                    lo_q <= lo_d;
                    // Hold at the terminal value instead of wrapping.
                    if (!last_iter) cnt_q <= cnt_q + 1'b1;
                    if (last_iter)  p_q   <= {hi_d, lo_d};
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.p    = p_q;

endmodule

// File: tb/tb_mul4_seq_ctrl.sv
// tb_mul4_seq_ctrl: directed bench for mul4_seq_ctrl. Inputs change and
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_mul4_seq_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mul4_seq_ctrl_if #(.W(W)) bus ();

    mul4_seq_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef MUL4_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = W;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call at a falling edge with the accept edge just behind us. Counts rising
    // edges until done, then checks latency, product and the return to idle.
    task automatic wait_done(input string tag, input logic [31:0] exp_p, input int exp_lat);
        int  n = 0;
        bit  seen = 0;
        while (n < 12 && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = bus.done;
            check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        end
        check({tag, "_lat"}, n, exp_lat);
        check({tag, "_p"}, {24'd0, bus.p}, exp_p);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_low"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_p_hold"}, {24'd0, bus.p}, exp_p);
    endtask

    // Call at a falling edge while the DUT is idle.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [31:0] exp_p, input int exp_lat);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        if (exp_lat == 1) begin
            check({tag, "_done_fast"}, {31'd0, bus.done}, 32'd1);
            check({tag, "_p"}, {24'd0, bus.p}, exp_p);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        end else begin
            check({tag, "_busy_rise"}, {31'd0, bus.busy}, 32'd1);
            check({tag, "_done_early"}, {31'd0, bus.done}, 32'd0);
            wait_done(tag, exp_p, exp_lat);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_p", {24'd0, bus.p}, 32'd0);

        // Reset wins over a simultaneous start.
        bus.start = 1'b1;
        bus.a     = 4'h3;
        bus.b     = 4'h3;
        @(posedge clk);
        @(negedge clk);
        check("rst_start_busy", {31'd0, bus.busy}, 32'd0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        @(negedge clk);

        run_op("m3x5", 4'h3, 4'h5, 32'h0F, W);
        run_op("mFxF", 4'hF, 4'hF, 32'hE1, W);
        run_op("mCx6", 4'hC, 4'h6, 32'h48, W);
        run_op("m1x1", 4'h1, 4'h1, 32'h01, W);

        // start held high with operands changing during RUN.
        bus.start = 1'b1;
        bus.a     = 4'h2;
        bus.b     = 4'h3;
        @(posedge clk);
        @(negedge clk);
        check("hold_busy", {31'd0, bus.busy}, 32'd1);
        bus.a = 4'hF;
        bus.b = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_no_done", {31'd0, bus.done}, 32'd0);
            bus.a = bus.a ^ 4'h5;
            bus.b = bus.b ^ 4'hA;
        end
        @(posedge clk);
        @(negedge clk);
        check("hold_done", {31'd0, bus.done}, 32'd1);
        check("hold_p", {24'd0, bus.p}, 32'h06);
        bus.a = 4'h5;
        bus.b = 4'h3;
        @(posedge clk);
        @(negedge clk);
        check("hold_gap_done", {31'd0, bus.done}, 32'd0);
        check("hold_gap_idle", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("hold_reaccept", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        bus.a     = 4'h0;
        bus.b     = 4'h0;
        wait_done("hold2", 32'h0F, W);

        // Reset mid-RUN at edge t+2.
        bus.start = 1'b1;
        bus.a     = 4'h7;
        bus.b     = 4'h7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_done", {31'd0, bus.done}, 32'd0);
        check("midrst_p", {24'd0, bus.p}, 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_quiet", {31'd0, bus.done}, 32'd0);
        end
        run_op("m9x9", 4'h9, 4'h9, 32'h51, W);

        run_op("m0xB", 4'h0, 4'hB, 32'h00, ZERO_LAT);
        run_op("mDx0", 4'hD, 4'h0, 32'h00, ZERO_LAT);
        run_op("mAx7", 4'hA, 4'h7, 32'h46, W);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
